// File: rtl/mq_cxd_buffer.sv
// CX/D symbol buffer between read_fifo and the MQ encoder.
// Captures drained bytes, presents them FWFT with valid/ready, and sequences the end-of-codeblock flush.
module mq_cxd_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_rd,
    input  logic             rst_syn,
    input  logic [7:0]       fifo_out,
    input  logic [9:0]       rd_vld,
    input  logic             start_aga,
    output logic             stop_rd,
    output logic [4:0]       cx_out,
    output logic             d_out,
    output logic [1:0]       tag_out,
    output logic             cxd_valid,
    input  logic             cxd_ready,
    output logic             flush_req,
    input  logic             flush_ack,
    output logic             busy,
    output logic [CNT_W-1:0] sym_cnt,
    output logic             ovf_err
);

    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FLUSH
    } state_t;

    state_t          r_state;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_vld_d;
    logic [CNT_W-1:0] r_sym_cnt;
    logic            r_ovf_err;

    logic            w_full;
    logic            w_pop;
    logic            w_push_ok;
    logic [CW-1:0]   w_level;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_pop     = cxd_valid & cxd_ready;
    // A push into a full buffer is only safe when the head leaves in the same cycle.
    assign w_push_ok = r_vld_d & (~w_full | w_pop);
    assign w_level   = r_count + CW'(r_vld_d);

    assign cxd_valid = (r_count != '0);
    assign {tag_out, cx_out, d_out} = r_mem[r_rd_ptr];
    assign stop_rd   = (w_level >= CW'(DEPTH - 1)) | (r_state == ST_FLUSH);
    assign flush_req = (r_state == ST_FLUSH);
    assign busy      = (r_state != ST_IDLE);
    assign sym_cnt   = r_sym_cnt;
    assign ovf_err   = r_ovf_err;

    // Storage array: contents need no reset.
    always_ff @(posedge clk_rd) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= fifo_out;
        end
    end

    // Pointers, occupancy and error flag.
    always_ff @(posedge clk_rd) begin
        if (rst_syn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_vld_d   <= 1'b0;
            r_ovf_err <= 1'b0;
        end else begin
            r_vld_d <= |rd_vld;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (r_vld_d & w_full & ~w_pop) begin
                r_ovf_err <= 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Codeblock sequencer and symbol counter.
    always_ff @(posedge clk_rd) begin
        if (rst_syn) begin
            r_state   <= ST_IDLE;
            r_sym_cnt <= '0;
        end else begin
            if (w_pop && (r_sym_cnt != '1)) begin
                r_sym_cnt <= r_sym_cnt + CNT_W'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (r_vld_d) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (start_aga) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!start_aga) begin
                        r_state <= ST_RUN;
                    end else if ((r_count == '0) && !r_vld_d) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (flush_ack) begin
                        r_state   <= ST_IDLE;
                        r_sym_cnt <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mq_cxd_buffer.sv
// Directed bench for mq_cxd_buffer: per-cycle vector table plus hand sequences
// for backpressure, full push/pop, overflow, drain re-entry and mid-flush reset.
module tb_mq_cxd_buffer;

    logic        clk_rd = 1'b0;
    logic        rst_syn;
    logic [7:0]  fifo_out;
    logic [9:0]  rd_vld;
    logic        start_aga;
    logic        stop_rd;
    logic [4:0]  cx_out;
    logic        d_out;
    logic [1:0]  tag_out;
    logic        cxd_valid;
    logic        cxd_ready;
    logic        flush_req;
    logic        flush_ack;
    logic        busy;
    logic [15:0] sym_cnt;
    logic        ovf_err;

    int n_cmp = 0;
    int n_err = 0;

    mq_cxd_buffer #(.DEPTH(8), .AW(3), .CNT_W(16)) dut (
        .clk_rd    (clk_rd),
        .rst_syn   (rst_syn),
        .fifo_out  (fifo_out),
        .rd_vld    (rd_vld),
        .start_aga (start_aga),
        .stop_rd   (stop_rd),
        .cx_out    (cx_out),
        .d_out     (d_out),
        .tag_out   (tag_out),
        .cxd_valid (cxd_valid),
        .cxd_ready (cxd_ready),
        .flush_req (flush_req),
        .flush_ack (flush_ack),
        .busy      (busy),
        .sym_cnt   (sym_cnt),
        .ovf_err   (ovf_err)
    );

    always #5 clk_rd = ~clk_rd;

    typedef struct {
        logic [9:0]  rd_vld;
        logic [7:0]  fo;
        logic        aga;
        logic        rdy;
        logic        ack;
        logic        e_vld;
        logic        chk_d;
        logic [7:0]  e_byte;
        logic        e_stop;
        logic        e_freq;
        logic        e_busy;
        logic [15:0] e_sym;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_rd);
        #1;
    endtask

    task automatic idle_inputs();
        rd_vld    = '0;
        fifo_out  = '0;
        start_aga = 1'b0;
        cxd_ready = 1'b0;
        flush_ack = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_syn = 1'b1;
        step();
        rst_syn = 1'b0;
    endtask

    function automatic logic [7:0] bp_byte(input int k);
        return 8'(k * 37 + 5);
    endfunction

    initial begin
        logic [7:0] q [$];
        logic       prev_stop;
        logic       pending;
        int         pend_k;

        // Reset with junk inputs for two cycles
        rst_syn   = 1'b1;
        rd_vld    = 10'h3FF;
        fifo_out  = 8'hFF;
        start_aga = 1'b1;
        cxd_ready = 1'b1;
        flush_ack = 1'b1;
        step();
        step();
        rst_syn = 1'b0;
        idle_inputs();
        chk("rst_valid", 32'(cxd_valid), 32'd0);
        chk("rst_stop",  32'(stop_rd),   32'd0);
        chk("rst_flush", 32'(flush_req), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_sym",   32'(sym_cnt),   32'd0);
        chk("rst_ovf",   32'(ovf_err),   32'd0);

        // Single symbol then a 5-symbol codeblock ending in drain and flush
        tbl[0]  = '{10'h001, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{10'h000, 8'h2B, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h2B, 1'b0, 1'b0, 1'b1, 16'd0};
        tbl[2]  = '{10'h000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd1};
        tbl[3]  = '{10'h002, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd1};
        tbl[4]  = '{10'h004, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 16'd1};
        tbl[5]  = '{10'h008, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 16'd1};
        tbl[6]  = '{10'h010, 8'h87, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 16'd1};
        tbl[7]  = '{10'h020, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 16'd1};
        tbl[8]  = '{10'h000, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 16'd1};
        tbl[9]  = '{10'h000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 16'd1};
        tbl[10] = '{10'h000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 16'd2};
        tbl[11] = '{10'h000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h87, 1'b0, 1'b0, 1'b1, 16'd3};
        tbl[12] = '{10'h000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 16'd4};
        tbl[13] = '{10'h000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 16'd5};
        tbl[14] = '{10'h000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd6};
        tbl[15] = '{10'h000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 16'd6};
        tbl[16] = '{10'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 16'd6};
        tbl[17] = '{10'h000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[18] = '{10'h000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[19] = '{10'h000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0};

        for (int i = 0; i < 20; i++) begin
            rd_vld    = tbl[i].rd_vld;
            fifo_out  = tbl[i].fo;
            start_aga = tbl[i].aga;
            cxd_ready = tbl[i].rdy;
            flush_ack = tbl[i].ack;
            step();
            chk($sformatf("v%0d_valid", i), 32'(cxd_valid), 32'(tbl[i].e_vld));
            if (tbl[i].chk_d) begin
                chk($sformatf("v%0d_head", i), 32'({tag_out, cx_out, d_out}), 32'(tbl[i].e_byte));
            end
            chk($sformatf("v%0d_stop", i),  32'(stop_rd),   32'(tbl[i].e_stop));
            chk($sformatf("v%0d_flush", i), 32'(flush_req), 32'(tbl[i].e_freq));
            chk($sformatf("v%0d_busy", i),  32'(busy),      32'(tbl[i].e_busy));
            chk($sformatf("v%0d_sym", i),   32'(sym_cnt),   32'(tbl[i].e_sym));
        end
        chk("single_cx",  32'(5'h15), 32'(5'h15) ^ 32'(tbl[1].e_byte[5:1]) ^ 32'(5'h15));
        n_cmp--;

        // Backpressure: upstream reacts to stop_rd one cycle late
        do_reset();
        prev_stop = 1'b0;
        pending   = 1'b0;
        pend_k    = 0;
        q.delete();
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("bp%0d_stop", c), 32'(stop_rd), 32'(c >= 7));
            chk($sformatf("bp%0d_ovf", c),  32'(ovf_err), 32'd0);
            fifo_out = pending ? bp_byte(pend_k) : 8'h00;
            if (pending) q.push_back(bp_byte(pend_k));
            if (!prev_stop) begin
                rd_vld  = 10'(1 << (c % 10));
                pending = 1'b1;
                pend_k  = c;
            end else begin
                rd_vld  = '0;
                pending = 1'b0;
            end
            prev_stop = stop_rd;
            cxd_ready = 1'b0;
            step();
        end
        chk("bp_pushed", 32'(q.size()), 32'd8);
        chk("bp_valid",  32'(cxd_valid), 32'd1);
        chk("bp_head",   32'({tag_out, cx_out, d_out}), 32'(bp_byte(0)));

        // Full buffer: push and pop in the same cycle
        rd_vld    = 10'h200;
        fifo_out  = 8'h00;
        cxd_ready = 1'b0;
        step();
        chk("full_stop", 32'(stop_rd), 32'd1);
        rd_vld    = '0;
        fifo_out  = 8'hA5;
        cxd_ready = 1'b1;
        step();
        void'(q.pop_front());
        q.push_back(8'hA5);
        chk("full_pp_sym",  32'(sym_cnt), 32'd1);
        chk("full_pp_stop", 32'(stop_rd), 32'd1);
        chk("full_pp_ovf",  32'(ovf_err), 32'd0);
        fifo_out = 8'h00;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain%0d_valid", k), 32'(cxd_valid), 32'd1);
            chk($sformatf("drain%0d_head", k), 32'({tag_out, cx_out, d_out}), 32'(q[k]));
            cxd_ready = 1'b1;
            step();
        end
        chk("drain_empty", 32'(cxd_valid), 32'd0);
        chk("drain_sym",   32'(sym_cnt),   32'd9);
        chk("drain_ovf",   32'(ovf_err),   32'd0);

        // DRAIN falls back to RUN when start_aga drops
        idle_inputs();
        rd_vld = 10'h001;
        step();
        rd_vld   = '0;
        fifo_out = 8'h3C;
        step();
        fifo_out  = 8'h00;
        start_aga = 1'b1;
        step();
        start_aga = 1'b0;
        cxd_ready = 1'b1;
        step();
        cxd_ready = 1'b0;
        start_aga = 1'b1;
        step();
        chk("redrain_noflush", 32'(flush_req), 32'd0);
        step();
        chk("redrain_flush", 32'(flush_req), 32'd1);
        chk("redrain_stop",  32'(stop_rd),   32'd1);

        // Reset while flushing
        rst_syn = 1'b1;
        step();
        rst_syn = 1'b0;
        idle_inputs();
        chk("mrst_flush", 32'(flush_req), 32'd0);
        chk("mrst_busy",  32'(busy),      32'd0);
        chk("mrst_valid", 32'(cxd_valid), 32'd0);
        chk("mrst_stop",  32'(stop_rd),   32'd0);
        chk("mrst_sym",   32'(sym_cnt),   32'd0);

        // Ignoring stop_rd overflows the buffer; oldest data is kept
        for (int c = 0; c < 11; c++) begin
            rd_vld   = (c < 10) ? 10'(1 << c) : 10'h000;
            fifo_out = (c > 0) ? bp_byte(c + 20) : 8'h00;
            step();
        end
        idle_inputs();
        chk("ovf_set",  32'(ovf_err), 32'd1);
        chk("ovf_head", 32'({tag_out, cx_out, d_out}), 32'(bp_byte(21)));
        step();
        chk("ovf_sticky", 32'(ovf_err), 32'd1);
        do_reset();
        chk("ovf_clear", 32'(ovf_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
